// File: rtl/vgafb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vgafb_pkg
// Description : Shared register map, default timing and layer-offset encoding
//               for the multi-layer VGA framebuffer control interface.
// Revision    : 1.0 - initial release
// ============================================================================
package vgafb_pkg;

    // Global register indices (csr_a[7:0])
    localparam logic [7:0] REG_CTRL        = 8'd0;
    localparam logic [7:0] REG_STATUS      = 8'd1;
    localparam logic [7:0] REG_HRES        = 8'd2;
    localparam logic [7:0] REG_HSYNC_START = 8'd3;
    localparam logic [7:0] REG_HSYNC_END   = 8'd4;
    localparam logic [7:0] REG_HSCAN       = 8'd5;
    localparam logic [7:0] REG_VRES        = 8'd6;
    localparam logic [7:0] REG_VSYNC_START = 8'd7;
    localparam logic [7:0] REG_VSYNC_END   = 8'd8;
    localparam logic [7:0] REG_VSCAN       = 8'd9;
    localparam logic [7:0] REG_COMMIT      = 8'd10;
    localparam logic [7:0] REG_CLKSEL      = 8'd11;

    // Per-layer register window
    localparam int LAYER_BASE   = 16;
    localparam int LAYER_STRIDE = 4;

    // Timing register file: hres..vscan in index order
    localparam int NUM_TIMING = 8;

    localparam int DEF_HRES        = 640;
    localparam int DEF_HSYNC_START = 656;
    localparam int DEF_HSYNC_END   = 752;
    localparam int DEF_HSCAN       = 799;
    localparam int DEF_VRES        = 480;
    localparam int DEF_VSYNC_START = 491;
    localparam int DEF_VSYNC_END   = 493;
    localparam int DEF_VSCAN       = 523;

    localparam logic [17:0] NBURSTS_DEFAULT = 18'd19200;

    // Offsets inside one layer's four-register window
    typedef enum logic [1:0] {
        LOFS_BASE     = 2'd0,
        LOFS_BASE_ACT = 2'd1,
        LOFS_NBURSTS  = 2'd2,
        LOFS_ENABLE   = 2'd3
    } layer_ofs_e;

    // Reset value of timing register k (0 = hres ... 7 = vscan)
    function automatic int timing_default(input int k);
        case (k)
            0:       return DEF_HRES;
            1:       return DEF_HSYNC_START;
            2:       return DEF_HSYNC_END;
            3:       return DEF_HSCAN;
            4:       return DEF_VRES;
            5:       return DEF_VSYNC_START;
            6:       return DEF_VSYNC_END;
            default: return DEF_VSCAN;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/vgafb_ctlif_layer.sv
`default_nettype none
// ============================================================================
// Module      : vgafb_ctlif_layer
// Description : One framebuffer layer: requested/active DMA base address with
//               ack tracking, burst count, enable bit and the read mux for the
//               layer's four register offsets.
// Revision    : 1.0 - initial release
// ============================================================================
module vgafb_ctlif_layer
    import vgafb_pkg::*;
#(
    parameter int fml_depth  = 26,
    parameter bit is_primary = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [1:0]           ofs,
    input  logic [31:0]          di,
    input  logic                 ack,
    output logic [31:0]          rdata,
    output logic [fml_depth-1:0] baseaddress,
    output logic                 addr_pend,
    output logic [17:0]          nbursts,
    output logic                 layer_en
);

    logic [fml_depth-1:0] baseaddress_act;
    logic                 unused_di;

    assign unused_di = ^di;

    // Register writes and ack handling; a write on the ack cycle keeps the
    // address pending and the ack captures the address from before the write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baseaddress     <= '0;
            baseaddress_act <= '0;
            addr_pend       <= 1'b0;
            nbursts         <= is_primary ? NBURSTS_DEFAULT : 18'd0;
            layer_en        <= is_primary;
        end else begin
            if (ack) begin
                baseaddress_act <= baseaddress;
                addr_pend       <= 1'b0;
            end
            if (we) begin
                case (layer_ofs_e'(ofs))
                    LOFS_BASE: begin
                        baseaddress <= di[fml_depth-1:0];
                        addr_pend   <= 1'b1;
                    end
                    LOFS_NBURSTS: nbursts  <= di[17:0];
                    LOFS_ENABLE:  layer_en <= di[0];
                    default: ;
                endcase
            end
        end
    end

    // Read mux for this layer's window
    always_comb begin
        rdata = '0;
        case (layer_ofs_e'(ofs))
            LOFS_BASE:     rdata = 32'(baseaddress);
            LOFS_BASE_ACT: rdata = 32'(baseaddress_act);
            LOFS_NBURSTS:  rdata = 32'(nbursts);
            LOFS_ENABLE:   rdata = {31'd0, layer_en};
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/vgafb_ctlif_mc.sv
`default_nettype none
// ============================================================================
// Module      : vgafb_ctlif_mc
// Description : CSR control interface for the multi-layer VGA framebuffer.
//               Shadow timing bank with frame-synchronous atomic commit,
//               per-layer DMA control and a maskable frame interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module vgafb_ctlif_mc
    import vgafb_pkg::*;
#(
    parameter logic [3:0] csr_addr  = 4'h0,
    parameter int         fml_depth = 26,
    parameter int         nlayers   = 2,
    parameter int         tw        = 11
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst,
    input  logic [13:0]                  csr_a,
    input  logic                         csr_we,
    input  logic [31:0]                  csr_di,
    output logic [31:0]                  csr_do,
    output logic                         irq,
    input  logic                         frame_start,
    output logic                         vga_rst,
    output logic [tw-1:0]                hres,
    output logic [tw-1:0]                hsync_start,
    output logic [tw-1:0]                hsync_end,
    output logic [tw-1:0]                hscan,
    output logic [tw-1:0]                vres,
    output logic [tw-1:0]                vsync_start,
    output logic [tw-1:0]                vsync_end,
    output logic [tw-1:0]                vscan,
    output logic [nlayers*fml_depth-1:0] baseaddress,
    input  logic [nlayers-1:0]           baseaddress_ack,
    output logic [nlayers*18-1:0]        nbursts,
    output logic [nlayers-1:0]           layer_en,
    output logic [1:0]                   vga_clk_sel
);

    logic          bank_sel;
    logic [7:0]    idx;
    logic          csr_wr;
    logic          irq_en;
    logic          frame_pend;
    logic          commit_armed;
    logic          commit_now;
    logic [31:0]   rd_mux;
    logic          unused_addr;

    logic [tw-1:0] shadow [NUM_TIMING];
    logic [tw-1:0] active [NUM_TIMING];

    logic [nlayers-1:0] layer_hit;
    logic [nlayers-1:0] addr_pend;
    logic [31:0]        layer_rdata [nlayers];

    assign bank_sel    = (csr_a[13:10] == csr_addr);
    assign idx         = csr_a[7:0];
    assign csr_wr      = bank_sel & csr_we;
    assign unused_addr = ^csr_a[9:8];

    // A commit only happens on a frame boundary while the core runs
    assign commit_now = ~vga_rst & frame_start & commit_armed;
    assign irq        = frame_pend & irq_en;

    // Global control, interrupt pending, commit arming and clock select
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            vga_rst      <= 1'b1;
            irq_en       <= 1'b0;
            frame_pend   <= 1'b0;
            commit_armed <= 1'b0;
            vga_clk_sel  <= 2'd0;
        end else begin
            if (csr_wr && idx == REG_CTRL) begin
                vga_rst <= csr_di[0];
                irq_en  <= csr_di[1];
            end
            // frame_start is placed after the W1C so a coincident set wins
            if (csr_wr && idx == REG_STATUS && csr_di[0])
                frame_pend <= 1'b0;
            if (frame_start)
                frame_pend <= 1'b1;
            // A COMMIT write on the commit edge re-arms for the next frame
            if (commit_now)
                commit_armed <= 1'b0;
            if (csr_wr && idx == REG_COMMIT && csr_di[0])
                commit_armed <= 1'b1;
            if (csr_wr && idx == REG_CLKSEL)
                vga_clk_sel <= csr_di[1:0];
        end
    end

    // Shadow timing bank and its copy into the active set; the copy always
    // sees the shadow value from before any same-cycle shadow write
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int k = 0; k < NUM_TIMING; k++) begin
                shadow[k] <= tw'(timing_default(k));
                active[k] <= tw'(timing_default(k));
            end
        end else begin
            if (vga_rst || commit_now) begin
                for (int k = 0; k < NUM_TIMING; k++)
                    active[k] <= shadow[k];
            end
            if (csr_wr && idx >= REG_HRES && idx <= REG_VSCAN)
                shadow[3'(idx - REG_HRES)] <= csr_di[tw-1:0];
        end
    end

    assign hres        = active[0];
    assign hsync_start = active[1];
    assign hsync_end   = active[2];
    assign hscan       = active[3];
    assign vres        = active[4];
    assign vsync_start = active[5];
    assign vsync_end   = active[6];
    assign vscan       = active[7];

    generate
        for (genvar i = 0; i < nlayers; i++) begin : g_layer
            assign layer_hit[i] = (idx[7:2] == 6'((LAYER_BASE / LAYER_STRIDE) + i));

            vgafb_ctlif_layer #(
                .fml_depth  (fml_depth),
                .is_primary (i == 0)
            ) u_layer (
                .clk         (sys_clk),
                .rst         (sys_rst),
                .we          (csr_wr & layer_hit[i]),
                .ofs         (idx[1:0]),
                .di          (csr_di),
                .ack         (baseaddress_ack[i]),
                .rdata       (layer_rdata[i]),
                .baseaddress (baseaddress[i*fml_depth +: fml_depth]),
                .addr_pend   (addr_pend[i]),
                .nbursts     (nbursts[i*18 +: 18]),
                .layer_en    (layer_en[i])
            );
        end
    endgenerate

    // Register read mux; unmapped indices read as zero
    always_comb begin
        rd_mux = '0;
        case (idx)
            REG_CTRL:   rd_mux = {30'd0, irq_en, vga_rst};
            REG_STATUS: begin
                rd_mux[0] = frame_pend;
                for (int i = 0; i < nlayers; i++)
                    rd_mux[8 + i] = addr_pend[i];
            end
            REG_HRES, REG_HSYNC_START, REG_HSYNC_END, REG_HSCAN,
            REG_VRES, REG_VSYNC_START, REG_VSYNC_END, REG_VSCAN:
                rd_mux = 32'(shadow[3'(idx - REG_HRES)]);
            REG_COMMIT: rd_mux = {31'd0, commit_armed};
            REG_CLKSEL: rd_mux = {30'd0, vga_clk_sel};
            default: ;
        endcase
        for (int i = 0; i < nlayers; i++)
            if (layer_hit[i])
                rd_mux = layer_rdata[i];
    end

    // Registered read data, zero when another bank is addressed
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)
            csr_do <= '0;
        else
            csr_do <= bank_sel ? rd_mux : 32'd0;
    end

endmodule
`default_nettype wire

// File: tb/tb_vgafb_ctlif_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_vgafb_ctlif_mc
// Description : Directed self-checking bench for vgafb_ctlif_mc.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vgafb_ctlif_mc;

    localparam int FD = 26;
    localparam int NL = 2;
    localparam int TW = 11;

    logic              sys_clk = 1'b0;
    logic              sys_rst = 1'b0;
    logic [13:0]       csr_a = '0;
    logic              csr_we = 1'b0;
    logic [31:0]       csr_di = '0;
    logic [31:0]       csr_do;
    logic              irq;
    logic              frame_start = 1'b0;
    logic              vga_rst;
    logic [TW-1:0]     hres, hsync_start, hsync_end, hscan;
    logic [TW-1:0]     vres, vsync_start, vsync_end, vscan;
    logic [NL*FD-1:0]  baseaddress;
    logic [NL-1:0]     baseaddress_ack = '0;
    logic [NL*18-1:0]  nbursts;
    logic [NL-1:0]     layer_en;
    logic [1:0]        vga_clk_sel;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q [$];

    vgafb_ctlif_mc #(
        .csr_addr  (4'h0),
        .fml_depth (FD),
        .nlayers   (NL),
        .tw        (TW)
    ) dut (
        .sys_clk         (sys_clk),
        .sys_rst         (sys_rst),
        .csr_a           (csr_a),
        .csr_we          (csr_we),
        .csr_di          (csr_di),
        .csr_do          (csr_do),
        .irq             (irq),
        .frame_start     (frame_start),
        .vga_rst         (vga_rst),
        .hres            (hres),
        .hsync_start     (hsync_start),
        .hsync_end       (hsync_end),
        .hscan           (hscan),
        .vres            (vres),
        .vsync_start     (vsync_start),
        .vsync_end       (vsync_end),
        .vscan           (vscan),
        .baseaddress     (baseaddress),
        .baseaddress_ack (baseaddress_ack),
        .nbursts         (nbursts),
        .layer_en        (layer_en),
        .vga_clk_sel     (vga_clk_sel)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic csr_write(input logic [7:0] idx, input logic [31:0] d,
                             input logic fs, input logic [NL-1:0] a);
        @(negedge sys_clk);
        csr_a = {4'h0, 2'b00, idx};
        csr_di = d;
        csr_we = 1'b1;
        frame_start = fs;
        baseaddress_ack = a;
        @(negedge sys_clk);
        csr_we = 1'b0;
        csr_di = '0;
        frame_start = 1'b0;
        baseaddress_ack = '0;
    endtask

    // Expected value is queued with the address; popped when csr_do is valid
    task automatic csr_read(input logic [3:0] bank, input logic [7:0] idx, input logic [31:0] expv);
        logic [31:0] e;
        @(negedge sys_clk);
        csr_a = {bank, 2'b00, idx};
        csr_we = 1'b0;
        exp_q.push_back(expv);
        @(negedge sys_clk);
        e = exp_q.pop_front();
        check($sformatf("rd[%0h:%0d]", bank, idx), 64'(csr_do), 64'(e));
    endtask

    task automatic pulse_fs();
        @(negedge sys_clk);
        frame_start = 1'b1;
        @(negedge sys_clk);
        frame_start = 1'b0;
    endtask

    task automatic pulse_ack(input logic [NL-1:0] a);
        @(negedge sys_clk);
        baseaddress_ack = a;
        @(negedge sys_clk);
        baseaddress_ack = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int defs [8];
        defs = '{640, 656, 752, 799, 480, 491, 493, 523};

        #1 sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        check("rst_csr_do", 64'(csr_do), 64'd0);
        check("rst_vga_rst", 64'(vga_rst), 64'd1);
        check("rst_irq", 64'(irq), 64'd0);
        check("rst_hres", 64'(hres), 64'd640);
        check("rst_vscan", 64'(vscan), 64'd523);
        check("rst_base", 64'(baseaddress), 64'd0);
        check("rst_nbursts", 64'(nbursts), 64'({18'd0, 18'd19200}));
        check("rst_layer_en", 64'(layer_en), 64'(2'b01));
        check("rst_clksel", 64'(vga_clk_sel), 64'd0);
        sys_rst = 1'b0;

        for (int k = 0; k < 8; k++)
            csr_read(4'h0, 8'(2 + k), 32'(defs[k]));
        csr_read(4'h0, 8'd18, 32'd19200);
        csr_read(4'h0, 8'd0, 32'd1);

        // Held in reset: shadow write reaches the active set without a commit
        csr_write(8'd9, 32'd600, 1'b0, 2'b00);
        @(negedge sys_clk);
        check("vscan_track", 64'(vscan), 64'd600);

        // Core running: no commit means no change across a frame
        csr_write(8'd0, 32'd0, 1'b0, 2'b00);
        check("vga_rst_off", 64'(vga_rst), 64'd0);
        csr_write(8'd2, 32'd800, 1'b0, 2'b00);
        pulse_fs();
        check("hres_nocommit", 64'(hres), 64'd640);
        csr_read(4'h0, 8'd10, 32'd0);

        csr_write(8'd10, 32'd1, 1'b0, 2'b00);
        csr_read(4'h0, 8'd10, 32'd1);
        pulse_fs();
        check("hres_commit", 64'(hres), 64'd800);
        csr_read(4'h0, 8'd10, 32'd0);

        // COMMIT coincident with frame_start arms only for the next frame
        csr_write(8'd2, 32'd1000, 1'b0, 2'b00);
        csr_write(8'd10, 32'd1, 1'b1, 2'b00);
        check("hres_coinc", 64'(hres), 64'd800);
        csr_read(4'h0, 8'd10, 32'd1);
        pulse_fs();
        check("hres_next", 64'(hres), 64'd1000);
        check("vscan_keep", 64'(vscan), 64'd600);

        // Layer base address tracking
        csr_write(8'd1, 32'd1, 1'b0, 2'b00);
        csr_read(4'h0, 8'd1, 32'd0);
        csr_write(8'd20, 32'h0012_3400, 1'b0, 2'b00);
        csr_read(4'h0, 8'd1, 32'h200);
        check("base1_out", 64'(baseaddress[FD +: FD]), 64'h12_3400);
        pulse_ack(2'b10);
        csr_read(4'h0, 8'd21, 32'h0012_3400);
        csr_read(4'h0, 8'd1, 32'h0);
        csr_write(8'd20, 32'h0020_0000, 1'b0, 2'b00);
        csr_write(8'd20, 32'h0005_5500, 1'b0, 2'b10);
        csr_read(4'h0, 8'd21, 32'h0020_0000);
        csr_read(4'h0, 8'd1, 32'h200);
        csr_read(4'h0, 8'd20, 32'h0005_5500);
        pulse_ack(2'b10);
        csr_read(4'h0, 8'd21, 32'h0005_5500);
        csr_read(4'h0, 8'd1, 32'h0);
        csr_read(4'h0, 8'd17, 32'h0);

        // Interrupt
        csr_write(8'd0, 32'd2, 1'b0, 2'b00);
        check("irq_idle", 64'(irq), 64'd0);
        pulse_fs();
        check("irq_set", 64'(irq), 64'd1);
        csr_write(8'd1, 32'd1, 1'b0, 2'b00);
        check("irq_w1c", 64'(irq), 64'd0);
        csr_write(8'd1, 32'd1, 1'b1, 2'b00);
        check("irq_setwins", 64'(irq), 64'd1);
        csr_read(4'h0, 8'd1, 32'd1);

        // Unmapped layer and other bank
        csr_read(4'h0, 8'd24, 32'd0);
        csr_read(4'h0, 8'd12, 32'd0);
        csr_write(8'd24, 32'hFFFF_FFFF, 1'b0, 2'b00);
        csr_write(8'd26, 32'hFFFF_FFFF, 1'b0, 2'b00);
        csr_write(8'd27, 32'd1, 1'b0, 2'b00);
        check("unmapped_base", 64'(baseaddress), 64'({26'h005_5500, 26'h0}));
        check("unmapped_nb", 64'(nbursts), 64'({18'd0, 18'd19200}));
        check("unmapped_en", 64'(layer_en), 64'(2'b01));
        csr_read(4'h1, 8'd2, 32'd0);

        // Layer 1 burst count / enable and clock select
        csr_write(8'd22, 32'hFFFC_0001, 1'b0, 2'b00);
        csr_read(4'h0, 8'd22, 32'd1);
        check("nb1_out", 64'(nbursts[18 +: 18]), 64'd1);
        csr_write(8'd23, 32'd1, 1'b0, 2'b00);
        check("en1_out", 64'(layer_en), 64'(2'b11));
        csr_write(8'd11, 32'd3, 1'b0, 2'b00);
        check("clksel", 64'(vga_clk_sel), 64'd3);
        csr_read(4'h0, 8'd11, 32'd3);

        // Asynchronous reset mid-frame with a commit armed
        csr_write(8'd10, 32'd1, 1'b0, 2'b00);
        @(negedge sys_clk);
        #2 sys_rst = 1'b1;
        #1;
        check("arst_vga_rst", 64'(vga_rst), 64'd1);
        check("arst_hres", 64'(hres), 64'd640);
        check("arst_vscan", 64'(vscan), 64'd523);
        check("arst_irq", 64'(irq), 64'd0);
        check("arst_csr_do", 64'(csr_do), 64'd0);
        check("arst_en", 64'(layer_en), 64'(2'b01));
        check("arst_base", 64'(baseaddress), 64'd0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        csr_read(4'h0, 8'd10, 32'd0);
        csr_read(4'h0, 8'd21, 32'd0);
        csr_read(4'h0, 8'd1, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
